// File: rtl/median_frame_scheduler.sv
// -----------------------------------------------------------------------------
// median_frame_scheduler
//
// Raster-scan controller for a free-running 3x3 median core. Pixels arrive one
// per cycle in row-major order. Two line buffers supply the two rows above the
// incoming pixel, so each accepted pixel produces one 3-pixel column
// (A = row y-2, B = row y-1, C = row y) for the core. A tag pipeline, as deep
// as the core latency, follows every column through the core. Only windows
// that lie fully inside the frame are flagged valid, so the (W-2)x(H-2)
// interior is emitted with no border padding.
//
// The core shifts its window on every clock edge. A cycle in which no pixel is
// accepted therefore pushes a stale column into it. Before the next interior
// pixel is accepted, the two previous columns of the current row are replayed
// from a short history. This makes the window x-2..x contiguous again.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start_in         frame start pulse. Sampled in IDLE. A pulse in DONE is
//                    held and acted on in the following IDLE cycle.
//   pix_in           raster pixel
//   pix_valid_in     pix_in valid
//   pix_ready_out    pixel accepted on an edge where valid && ready
//   A_out/B_out/C_out column to the core: rows y-2, y-1, y at column x
//   median_in        median from the core
//   med_out          registered median
//   med_valid_out    one cycle per interior pixel
//   med_x_out        window centre column
//   med_y_out        window centre row
//   busy_out         high outside IDLE
//   done_out         one-cycle pulse when the frame has fully drained
// -----------------------------------------------------------------------------
module median_frame_scheduler #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_W     = 8,
  parameter int MEDIAN_LAT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_in,
  input  logic [DATA_W-1:0]             pix_in,
  input  logic                          pix_valid_in,
  output logic                          pix_ready_out,
  output logic [DATA_W-1:0]             A_out,
  output logic [DATA_W-1:0]             B_out,
  output logic [DATA_W-1:0]             C_out,
  input  logic [DATA_W-1:0]             median_in,
  output logic [DATA_W-1:0]             med_out,
  output logic                          med_valid_out,
  output logic [$clog2(IMG_WIDTH)-1:0]  med_x_out,
  output logic [$clog2(IMG_HEIGHT)-1:0] med_y_out,
  output logic                          busy_out,
  output logic                          done_out
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int CW = (MEDIAN_LAT > 1) ? $clog2(MEDIAN_LAT) : 1;
  localparam int COLW = 3 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_REPLAY1,
    S_REPLAY2,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_stale;
  logic              r_start_pend;
  logic [CW-1:0]     r_drain_cnt;

  logic              w_accept;
  logic              w_replay_go;
  logic              w_interior;
  logic              w_last_col;
  logic              w_last_row;

  // Line buffers: lb0 holds row y-1 and lb1 holds row y-2, indexed by column.
  logic [DATA_W-1:0] r_lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] r_lb1 [IMG_WIDTH];

  // Last two accepted columns: hist0 = column x-1, hist1 = column x-2.
  logic [COLW-1:0]   r_hist0;
  logic [COLW-1:0]   r_hist1;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;

  logic              r_tag_vld_p [MEDIAN_LAT];
  logic [XW-1:0]     r_tag_x_p   [MEDIAN_LAT];
  logic [YW-1:0]     r_tag_y_p   [MEDIAN_LAT];

  logic [DATA_W-1:0] r_med;
  logic              r_med_vld;
  logic [XW-1:0]     r_med_x;
  logic [YW-1:0]     r_med_y;

  assign w_interior = (r_x >= XW'(2)) && (r_y >= YW'(2));
  assign w_last_col = (r_x == XW'(IMG_WIDTH - 1));
  assign w_last_row = (r_y == YW'(IMG_HEIGHT - 1));
  assign w_accept   = pix_valid_in && pix_ready_out;

  // Next state and combinational outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_replay_go   = 1'b0;
    pix_ready_out = 1'b0;
    busy_out      = 1'b1;
    done_out      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in || r_start_pend) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // A stale core window is rebuilt before an interior pixel is taken.
        // Ready therefore stays low on the cycle that makes this decision.
        if (r_stale && pix_valid_in && w_interior) begin
          w_replay_go = 1'b1;
          w_state_nxt = S_REPLAY1;
        end else begin
          pix_ready_out = 1'b1;
          if (pix_valid_in && w_last_col && w_last_row) w_state_nxt = S_DRAIN;
        end
      end
      S_REPLAY1: w_state_nxt = S_REPLAY2;
      S_REPLAY2: w_state_nxt = S_RUN;
      S_DRAIN: begin
        if (r_drain_cnt == CW'(MEDIAN_LAT - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_out    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control: state, raster counters, stale flag, drain timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_stale      <= 1'b0;
      r_start_pend <= 1'b0;
      r_drain_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_pend <= (r_state == S_DONE) && start_in;

      if (w_accept) begin
        if (w_last_col) begin
          r_x <= '0;
          r_y <= w_last_row ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end

      // The core shifts on every edge, so any RUN cycle without an accept
      // leaves a garbage column in the window.
      if (r_state == S_IDLE) begin
        r_stale <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (w_replay_go) begin
          r_stale <= 1'b0;
        end else if (w_accept) begin
          if (r_x == '0) r_stale <= 1'b0;
        end else begin
          r_stale <= 1'b1;
        end
      end

      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + CW'(1);
      else                    r_drain_cnt <= '0;
    end
  end

  // Line buffers are pure storage; every entry is rewritten before it can
  // contribute to a valid window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_x] <= r_lb0[r_x];
      r_lb0[r_x] <= pix_in;
    end
  end

  // Stage p0: column into the core, either fresh or replayed from history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_hist0 <= '0;
      r_hist1 <= '0;
    end else if (w_accept) begin
      r_a     <= r_lb1[r_x];
      r_b     <= r_lb0[r_x];
      r_c     <= pix_in;
      r_hist1 <= r_hist0;
      r_hist0 <= {r_lb1[r_x], r_lb0[r_x], pix_in};
    end else if (r_state == S_REPLAY1) begin
      {r_a, r_b, r_c} <= r_hist1;
    end else if (r_state == S_REPLAY2) begin
      {r_a, r_b, r_c} <= r_hist0;
    end
  end

  assign A_out = r_a;
  assign B_out = r_b;
  assign C_out = r_c;

  // Tag pipeline: one entry per edge, matching the core's latency.
  // Columns 0 and 1 would mix in the previous row, so they are never valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEDIAN_LAT; i++) begin
        r_tag_vld_p[i] <= 1'b0;
        r_tag_x_p[i]   <= '0;
        r_tag_y_p[i]   <= '0;
      end
    end else begin
      r_tag_vld_p[0] <= w_accept && w_interior;
      r_tag_x_p[0]   <= r_x;
      r_tag_y_p[0]   <= r_y;
      for (int i = 1; i < MEDIAN_LAT; i++) begin
        r_tag_vld_p[i] <= r_tag_vld_p[i-1];
        r_tag_x_p[i]   <= r_tag_x_p[i-1];
        r_tag_y_p[i]   <= r_tag_y_p[i-1];
      end
    end
  end

  // Output stage: capture the core median when its tag is valid.
  // The window centre is one column left of and one row above the newest pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_med     <= '0;
      r_med_vld <= 1'b0;
      r_med_x   <= '0;
      r_med_y   <= '0;
    end else begin
      r_med_vld <= r_tag_vld_p[MEDIAN_LAT-1];
      if (r_tag_vld_p[MEDIAN_LAT-1]) begin
        r_med   <= median_in;
        r_med_x <= r_tag_x_p[MEDIAN_LAT-1] - XW'(1);
        r_med_y <= r_tag_y_p[MEDIAN_LAT-1] - YW'(1);
      end
    end
  end

  assign med_out       = r_med;
  assign med_valid_out = r_med_vld;
  assign med_x_out     = r_med_x;
  assign med_y_out     = r_med_y;

endmodule

// File: tb/tb_median_frame_scheduler.sv
module tb_median_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // 4x4 instance
  logic       start4, p4_valid, p4_ready, m4_v, busy4, done4;
  logic [7:0] p4_pix, a4, b4, c4, core4_med, m4_med;
  logic [1:0] m4_x, m4_y;

  // 5x5 instance
  logic       start5, p5_valid, p5_ready, m5_v, busy5, done5;
  logic [7:0] p5_pix, a5, b5, c5, core5_med, m5_med;
  logic [2:0] m5_x, m5_y;

  median_frame_scheduler #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(8), .MEDIAN_LAT(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_in(start4), .pix_in(p4_pix), .pix_valid_in(p4_valid),
    .pix_ready_out(p4_ready), .A_out(a4), .B_out(b4), .C_out(c4), .median_in(core4_med),
    .med_out(m4_med), .med_valid_out(m4_v), .med_x_out(m4_x), .med_y_out(m4_y),
    .busy_out(busy4), .done_out(done4));

  median_frame_scheduler #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .DATA_W(8), .MEDIAN_LAT(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .start_in(start5), .pix_in(p5_pix), .pix_valid_in(p5_valid),
    .pix_ready_out(p5_ready), .A_out(a5), .B_out(b5), .C_out(c5), .median_in(core5_med),
    .med_out(m5_med), .med_valid_out(m5_v), .med_x_out(m5_x), .med_y_out(m5_y),
    .busy_out(busy5), .done_out(done5));

  // Behavioural nine-median core: the window register takes a column one edge
  // after it appears on A/B/C, and the median is registered one edge later.
  // The scheduler samples median_in on the third edge.
  function automatic logic [7:0] median9(input logic [71:0] win);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) v[i] = win[i*8 +: 8];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  logic [23:0] w4_0, w4_1, w4_2, w5_0, w5_1, w5_2;
  always @(posedge clk) begin
    w4_0 <= {a4, b4, c4}; w4_1 <= w4_0; w4_2 <= w4_1;
    core4_med <= median9({w4_0, w4_1, w4_2});
    w5_0 <= {a5, b5, c5}; w5_1 <= w5_0; w5_2 <= w5_1;
    core5_med <= median9({w5_0, w5_1, w5_2});
  end

  function automatic int pk(input int x, input int y, input int v);
    return (x << 16) | (y << 8) | v;
  endfunction

  // Output monitors
  int q4 [$];
  int q4c [$];
  int q5 [$];
  int d4_cnt = 0;
  int d5_cnt = 0;
  always @(negedge clk) begin
    if (m4_v) begin
      q4.push_back(pk(int'(m4_x), int'(m4_y), int'(m4_med)));
      q4c.push_back(cyc);
    end
    if (m5_v) q5.push_back(pk(int'(m5_x), int'(m5_y), int'(m5_med)));
    if (done4) d4_cnt <= d4_cnt + 1;
    if (done5) d5_cnt <= d5_cnt + 1;
  end

  // Expected 4x4 interior for pixels 0..15, and the pixel index completing each window.
  int exp4 [4];
  int acc_idx [4];
  int acc4_cyc [16];

  task automatic start_frame4();
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  // Drive pixels 0..n_pix-1 into the 4x4 instance. An optional idle gap can be
  // inserted before one pixel, and an optional start pulse can be raised with another.
  task automatic drive4(input int n_pix, input int gap_idx, input int gap_len,
                        input int mid_start_idx, output int stall);
    logic acc;
    int   tries;
    stall = 0;
    for (int i = 0; i < n_pix; i++) begin
      if (i == gap_idx) begin
        p4_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      if (i == mid_start_idx) start4 = 1'b1;
      p4_pix   = 8'(i);
      p4_valid = 1'b1;
      acc      = 1'b0;
      tries    = 0;
      while (!acc && tries < 20) begin
        @(negedge clk);
        acc = p4_ready;
        if (!acc) stall++;
        @(posedge clk); #1;
        start4 = 1'b0;
        tries++;
      end
      if (!acc) begin
        checks++; fails++;
        $display("FAIL accept_timeout pixel=%0d ready never seen", i);
      end else begin
        acc4_cyc[i] = cyc;
      end
    end
    p4_valid = 1'b0;
  endtask

  task automatic wait_idle4();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!busy4) break;
    end
    checks++;
    if (busy4 !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout4 busy=%0b expected=0", busy4);
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_mon4();
    q4.delete();
    q4c.delete();
    d4_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start4 = 0; p4_valid = 0; p4_pix = 0;
    start5 = 0; p5_valid = 0; p5_pix = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({p4_ready, a4, b4, c4, m4_med, m4_v, m4_x, m4_y, busy4, done4} !== 40'h0) begin
      fails++;
      $display("FAIL reset_outputs4 got=%h expected=0",
               {p4_ready, a4, b4, c4, m4_med, m4_v, m4_x, m4_y, busy4, done4});
    end
    checks++;
    if ({p5_ready, a5, b5, c5, m5_med, m5_v, m5_x, m5_y, busy5, done5} !== 42'h0) begin
      fails++;
      $display("FAIL reset_outputs5 got=%h expected=0",
               {p5_ready, a5, b5, c5, m5_med, m5_v, m5_x, m5_y, busy5, done5});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame();
    int stall;
    int got;
    clear_mon4();
    start_frame4();
    drive4(16, -1, 0, -1, stall);
    wait_idle4();
    checks++;
    if (stall !== 0) begin fails++; $display("FAIL frame_stall got=%0d expected=0", stall); end
    checks++;
    if (q4.size() !== 4) begin fails++; $display("FAIL frame_count got=%0d expected=4", q4.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q4.size()) ? q4[i] : -1;
      checks++;
      if (got !== exp4[i]) begin
        fails++; $display("FAIL frame_med%0d got=%h expected=%h", i, got, exp4[i]);
      end
      got = (i < q4c.size()) ? q4c[i] : -1;
      checks++;
      if (got !== acc4_cyc[acc_idx[i]] + 3) begin
        fails++; $display("FAIL frame_lat%0d got=%0d expected=%0d", i, got, acc4_cyc[acc_idx[i]] + 3);
      end
    end
    checks++;
    if (d4_cnt !== 1) begin fails++; $display("FAIL frame_done got=%0d expected=1", d4_cnt); end
  endtask

  task automatic test_replay();
    int stall;
    int got;
    clear_mon4();
    start_frame4();
    // Gap before (x=3,y=2). Ready stays low on the decision cycle and on both replay cycles.
    drive4(16, 11, 3, -1, stall);
    wait_idle4();
    checks++;
    if (stall !== 3) begin fails++; $display("FAIL replay_stall got=%0d expected=3", stall); end
    checks++;
    if (q4.size() !== 4) begin fails++; $display("FAIL replay_count got=%0d expected=4", q4.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q4.size()) ? q4[i] : -1;
      checks++;
      if (got !== exp4[i]) begin
        fails++; $display("FAIL replay_med%0d got=%h expected=%h", i, got, exp4[i]);
      end
      got = (i < q4c.size()) ? q4c[i] : -1;
      checks++;
      if (got !== acc4_cyc[acc_idx[i]] + 3) begin
        fails++; $display("FAIL replay_lat%0d got=%0d expected=%0d", i, got, acc4_cyc[acc_idx[i]] + 3);
      end
    end
    checks++;
    if (d4_cnt !== 1) begin fails++; $display("FAIL replay_done got=%0d expected=1", d4_cnt); end
  endtask

  task automatic test_impulse();
    logic acc;
    int   tries;
    int   got;
    int   exp;
    q5.delete();
    d5_cnt = 0;
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      p5_pix   = (i == 12) ? 8'h00 : 8'hFF;
      p5_valid = 1'b1;
      acc = 1'b0; tries = 0;
      while (!acc && tries < 20) begin
        @(negedge clk); acc = p5_ready;
        @(posedge clk); #1; tries++;
      end
      if (!acc) begin
        checks++; fails++; $display("FAIL impulse_accept_timeout pixel=%0d", i);
      end
    end
    p5_valid = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!busy5) break;
    end
    @(posedge clk); #1;
    checks++;
    if (q5.size() !== 9) begin fails++; $display("FAIL impulse_count got=%0d expected=9", q5.size()); end
    for (int i = 0; i < 9; i++) begin
      exp = pk(1 + (i % 3), 1 + (i / 3), 255);
      got = (i < q5.size()) ? q5[i] : -1;
      checks++;
      if (got !== exp) begin fails++; $display("FAIL impulse_med%0d got=%h expected=%h", i, got, exp); end
    end
    checks++;
    if (d5_cnt !== 1) begin fails++; $display("FAIL impulse_done got=%0d expected=1", d5_cnt); end
  endtask

  task automatic test_midframe_reset();
    int stall;
    int got;
    clear_mon4();
    start_frame4();
    // Stop right after (2,2) is accepted, so a valid tag is still in flight.
    drive4(11, -1, 0, -1, stall);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({p4_ready, a4, b4, c4, m4_med, m4_v, m4_x, m4_y, busy4, done4} !== 40'h0) begin
      fails++;
      $display("FAIL midreset_outputs got=%h expected=0",
               {p4_ready, a4, b4, c4, m4_med, m4_v, m4_x, m4_y, busy4, done4});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (q4.size() !== 0) begin fails++; $display("FAIL midreset_flush got=%0d expected=0", q4.size()); end
    clear_mon4();
    start_frame4();
    drive4(16, -1, 0, -1, stall);
    wait_idle4();
    checks++;
    if (q4.size() !== 4) begin fails++; $display("FAIL restart_count got=%0d expected=4", q4.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q4.size()) ? q4[i] : -1;
      checks++;
      if (got !== exp4[i]) begin fails++; $display("FAIL restart_med%0d got=%h expected=%h", i, got, exp4[i]); end
    end
  endtask

  task automatic test_ignored();
    int stall;
    int got;
    clear_mon4();
    p4_pix   = 8'h77;
    p4_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({p4_ready, busy4} !== 2'b00) begin
        fails++; $display("FAIL idle_valid%0d ready_busy=%b expected=00", i, {p4_ready, busy4});
      end
      @(posedge clk); #1;
    end
    p4_valid = 1'b0;
    start_frame4();
    // Extra start pulse raised while pixel 5 is being offered.
    drive4(16, -1, 0, 5, stall);
    wait_idle4();
    checks++;
    if (q4.size() !== 4) begin fails++; $display("FAIL ignored_count got=%0d expected=4", q4.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q4.size()) ? q4[i] : -1;
      checks++;
      if (got !== exp4[i]) begin fails++; $display("FAIL ignored_med%0d got=%h expected=%h", i, got, exp4[i]); end
    end
    checks++;
    if (d4_cnt !== 1) begin fails++; $display("FAIL ignored_done got=%0d expected=1", d4_cnt); end
  endtask

  task automatic test_back_to_back();
    int   stall;
    int   got;
    logic seen;
    clear_mon4();
    start_frame4();
    drive4(16, -1, 0, -1, stall);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      seen = done4;
    end
    checks++;
    if (seen !== 1'b1) begin fails++; $display("FAIL b2b_done_wait got=%b expected=1", seen); end
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    drive4(16, -1, 0, -1, stall);
    wait_idle4();
    checks++;
    if (q4.size() !== 8) begin fails++; $display("FAIL b2b_count got=%0d expected=8", q4.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < q4.size()) ? q4[i] : -1;
      checks++;
      if (got !== exp4[i % 4]) begin fails++; $display("FAIL b2b_med%0d got=%h expected=%h", i, got, exp4[i % 4]); end
    end
    checks++;
    if (d4_cnt !== 2) begin fails++; $display("FAIL b2b_done got=%0d expected=2", d4_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pixel p = 4*y + x; median of each 3x3 block is its centre value.
    exp4[0] = pk(1, 1, 5);  acc_idx[0] = 10;
    exp4[1] = pk(2, 1, 6);  acc_idx[1] = 11;
    exp4[2] = pk(1, 2, 9);  acc_idx[2] = 14;
    exp4[3] = pk(2, 2, 10); acc_idx[3] = 15;
    for (int i = 0; i < 16; i++) acc4_cyc[i] = -100;

    test_reset();
    test_frame();
    test_replay();
    test_impulse();
    test_midframe_reset();
    test_ignored();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
